i2c_master_arbiter: RTL and testbench

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_master_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master, with a
// post-release holdoff, a per-grant inactivity watchdog and timeout lockout.
module i2c_master_arbiter #(
    parameter int WD_WIDTH = 20,
    parameter int HOLDOFF  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r0_req,
    input  logic       r0_go,
    input  logic       r0_rw,
    input  logic [5:0] r0_n_byte,
    input  logic [6:0] r0_slave_addr,
    input  logic [7:0] r0_data_write,
    input  logic [7:0] r0_reg_addr,
    input  logic       r0_stop,
    output logic       r0_gnt,
    output logic       r0_done,
    output logic       r0_ready,
    output logic       r0_timeout,
    output logic       r0_ack,
    output logic [7:0] r0_read_data,
    input  logic       r1_req,
    input  logic       r1_go,
    input  logic       r1_rw,
    input  logic [5:0] r1_n_byte,
    input  logic [6:0] r1_slave_addr,
    input  logic [7:0] r1_data_write,
    input  logic [7:0] r1_reg_addr,
    input  logic       r1_stop,
    output logic       r1_gnt,
    output logic       r1_done,
    output logic       r1_ready,
    output logic       r1_timeout,
    output logic       r1_ack,
    output logic [7:0] r1_read_data,
    output logic       m_go,
    output logic       m_rw,
    output logic       m_stop,
    output logic [5:0] m_n_byte,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_data_write,
    output logic [7:0] m_reg_addr,
    input  logic       m_done,
    input  logic       m_ready,
    input  logic       m_ack,
    input  logic [7:0] m_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [WD_WIDTH-1:0] WD_MAX  = {WD_WIDTH{1'b1}};
    localparam logic [WD_WIDTH-1:0] WD_LAST = {{(WD_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WD_WIDTH-1:0] WD_ONE  = {{(WD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]          HOLD_LAST = 4'(HOLDOFF - 1);

    state_t              state_r;
    logic                last_owner_r;
    logic                lock0_r;
    logic                lock1_r;
    logic [3:0]          hold_r;
    logic [WD_WIDTH-1:0] wd_r;

    logic elig0_s;
    logic elig1_s;
    logic wd_clear_s;
    logic wd_expire_s;

    assign elig0_s     = r0_req & ~lock0_r;
    assign elig1_s     = r1_req & ~lock1_r;
    assign wd_clear_s  = m_done | m_go;
    // Expire on the cycle the count would reach its maximum.
    assign wd_expire_s = ~wd_clear_s & (wd_r >= WD_LAST);

    assign r0_done      = m_done & r0_gnt;
    assign r1_done      = m_done & r1_gnt;
    assign r0_ready     = m_ready & r0_gnt;
    assign r1_ready     = m_ready & r1_gnt;
    assign r0_ack       = m_ack;
    assign r1_ack       = m_ack;
    assign r0_read_data = m_read_data;
    assign r1_read_data = m_read_data;

    // Route the granted requester's command fields to the master.
    always_comb begin
        m_go         = 1'b0;
        m_rw         = 1'b0;
        m_stop       = 1'b0;
        m_n_byte     = 6'd0;
        m_slave_addr = 7'd0;
        m_data_write = 8'd0;
        m_reg_addr   = 8'd0;
        if (r0_gnt) begin
            m_go         = r0_go;
            m_rw         = r0_rw;
            m_stop       = r0_stop;
            m_n_byte     = r0_n_byte;
            m_slave_addr = r0_slave_addr;
            m_data_write = r0_data_write;
            m_reg_addr   = r0_reg_addr;
        end else if (r1_gnt) begin
            m_go         = r1_go;
            m_rw         = r1_rw;
            m_stop       = r1_stop;
            m_n_byte     = r1_n_byte;
            m_slave_addr = r1_slave_addr;
            m_data_write = r1_data_write;
            m_reg_addr   = r1_reg_addr;
        end else begin
            m_go = 1'b0;
        end
    end

    // Arbitration FSM with registered grants, holdoff, watchdog and lockouts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_owner_r <= 1'b1;
            lock0_r      <= 1'b0;
            lock1_r      <= 1'b0;
            hold_r       <= 4'd0;
            wd_r         <= '0;
            r0_gnt       <= 1'b0;
            r1_gnt       <= 1'b0;
            r0_timeout   <= 1'b0;
            r1_timeout   <= 1'b0;
        end else begin
            r0_timeout <= 1'b0;
            r1_timeout <= 1'b0;
            // A lockout ends once the requester has been seen idle.
            if (!r0_req) lock0_r <= 1'b0;
            if (!r1_req) lock1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wd_r   <= '0;
                    hold_r <= 4'd0;
                    if (elig0_s && (!elig1_s || last_owner_r)) begin
                        state_r <= ST_GNT0;
                        r0_gnt  <= 1'b1;
                    end else if (elig1_s) begin
                        state_r <= ST_GNT1;
                        r1_gnt  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GNT0: begin
                    if (wd_expire_s) begin
                        state_r      <= ST_HOLD;
                        r0_gnt       <= 1'b0;
                        r0_timeout   <= 1'b1;
                        lock0_r      <= 1'b1;
                        last_owner_r <= 1'b0;
                        wd_r         <= '0;
                    end else if (!r0_req && m_ready) begin
                        state_r      <= ST_HOLD;
                        r0_gnt       <= 1'b0;
                        last_owner_r <= 1'b0;
                        wd_r         <= '0;
                    end else if (wd_clear_s) begin
                        wd_r <= '0;
                    end else if (wd_r != WD_MAX) begin
                        wd_r <= wd_r + WD_ONE;
                    end else begin
                        wd_r <= wd_r;
                    end
                end
                ST_GNT1: begin
                    if (wd_expire_s) begin
                        state_r      <= ST_HOLD;
                        r1_gnt       <= 1'b0;
                        r1_timeout   <= 1'b1;
                        lock1_r      <= 1'b1;
                        last_owner_r <= 1'b1;
                        wd_r         <= '0;
                    end else if (!r1_req && m_ready) begin
                        state_r      <= ST_HOLD;
                        r1_gnt       <= 1'b0;
                        last_owner_r <= 1'b1;
                        wd_r         <= '0;
                    end else if (wd_clear_s) begin
                        wd_r <= '0;
                    end else if (wd_r != WD_MAX) begin
                        wd_r <= wd_r + WD_ONE;
                    end else begin
                        wd_r <= wd_r;
                    end
                end
                ST_HOLD: begin
                    wd_r <= '0;
                    if (hold_r == HOLD_LAST) begin
                        state_r <= ST_IDLE;
                        hold_r  <= 4'd0;
                    end else begin
                        hold_r <= hold_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    r0_gnt  <= 1'b0;
                    r1_gnt  <= 1'b0;
                    hold_r  <= 4'd0;
                    wd_r    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter (WD_WIDTH=4, HOLDOFF=4) with
// hand-computed cycle-exact expectations.
module tb_i2c_master_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_req, r0_go, r0_rw, r0_stop;
    logic [5:0] r0_n_byte;
    logic [6:0] r0_slave_addr;
    logic [7:0] r0_data_write, r0_reg_addr;
    logic       r0_gnt, r0_done, r0_ready, r0_timeout, r0_ack;
    logic [7:0] r0_read_data;
    logic       r1_req, r1_go, r1_rw, r1_stop;
    logic [5:0] r1_n_byte;
    logic [6:0] r1_slave_addr;
    logic [7:0] r1_data_write, r1_reg_addr;
    logic       r1_gnt, r1_done, r1_ready, r1_timeout, r1_ack;
    logic [7:0] r1_read_data;
    logic       m_go, m_rw, m_stop;
    logic [5:0] m_n_byte;
    logic [6:0] m_slave_addr;
    logic [7:0] m_data_write, m_reg_addr;
    logic       m_done, m_ready, m_ack;
    logic [7:0] m_read_data;

    int checks_cnt = 0;
    int errors_cnt = 0;

    i2c_master_arbiter #(.WD_WIDTH(4), .HOLDOFF(4)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_go(r0_go), .r0_rw(r0_rw), .r0_n_byte(r0_n_byte),
        .r0_slave_addr(r0_slave_addr), .r0_data_write(r0_data_write),
        .r0_reg_addr(r0_reg_addr), .r0_stop(r0_stop), .r0_gnt(r0_gnt),
        .r0_done(r0_done), .r0_ready(r0_ready), .r0_timeout(r0_timeout),
        .r0_ack(r0_ack), .r0_read_data(r0_read_data),
        .r1_req(r1_req), .r1_go(r1_go), .r1_rw(r1_rw), .r1_n_byte(r1_n_byte),
        .r1_slave_addr(r1_slave_addr), .r1_data_write(r1_data_write),
        .r1_reg_addr(r1_reg_addr), .r1_stop(r1_stop), .r1_gnt(r1_gnt),
        .r1_done(r1_done), .r1_ready(r1_ready), .r1_timeout(r1_timeout),
        .r1_ack(r1_ack), .r1_read_data(r1_read_data),
        .m_go(m_go), .m_rw(m_rw), .m_stop(m_stop), .m_n_byte(m_n_byte),
        .m_slave_addr(m_slave_addr), .m_data_write(m_data_write),
        .m_reg_addr(m_reg_addr), .m_done(m_done), .m_ready(m_ready),
        .m_ack(m_ack), .m_read_data(m_read_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        r0_req = 1'b0; r0_go = 1'b0; r0_rw = 1'b0; r0_stop = 1'b0;
        r0_n_byte = 6'd0; r0_slave_addr = 7'd0; r0_data_write = 8'd0; r0_reg_addr = 8'd0;
        r1_req = 1'b0; r1_go = 1'b0; r1_rw = 1'b0; r1_stop = 1'b0;
        r1_n_byte = 6'd0; r1_slave_addr = 7'd0; r1_data_write = 8'd0; r1_reg_addr = 8'd0;
        m_done = 1'b0; m_ready = 1'b1; m_ack = 1'b1; m_read_data = 8'h5C;

        // Reset state, with requester 0 driving a go and an address
        r0_req = 1'b1; r0_go = 1'b1; r0_slave_addr = 7'h48;
        tick(); tick();
        check_val("rst_gnt0", 32'(r0_gnt), 32'd0);
        check_val("rst_gnt1", 32'(r1_gnt), 32'd0);
        check_val("rst_to0", 32'(r0_timeout), 32'd0);
        check_val("rst_m_go", 32'(m_go), 32'd0);
        check_val("rst_m_addr", 32'(m_slave_addr), 32'd0);
        check_val("bcast_rd", 32'(r1_read_data), 32'h5C);
        r0_go = 1'b0; r0_req = 1'b0;
        reset = 1'b0;

        // Single requester
        r0_req = 1'b1;
        tick();
        check_val("single_gnt0", 32'(r0_gnt), 32'd1);
        check_val("single_gnt1", 32'(r1_gnt), 32'd0);
        r0_go = 1'b1; r0_rw = 1'b0; r0_n_byte = 6'd2;
        r0_data_write = 8'hA5; r0_reg_addr = 8'h10;
        settle();
        check_val("echo_go", 32'(m_go), 32'd1);
        check_val("echo_addr", 32'(m_slave_addr), 32'h48);
        check_val("echo_nbyte", 32'(m_n_byte), 32'd2);
        check_val("echo_wdata", 32'(m_data_write), 32'hA5);
        check_val("echo_reg", 32'(m_reg_addr), 32'h10);
        tick();
        r0_go = 1'b0; m_done = 1'b1;
        settle();
        check_val("go_low", 32'(m_go), 32'd0);
        check_val("done0", 32'(r0_done), 32'd1);
        check_val("done1_q", 32'(r1_done), 32'd0);
        m_done = 1'b0; r0_req = 1'b0;
        settle();
        check_val("ready0", 32'(r0_ready), 32'd1);
        tick();
        check_val("rel_gnt0", 32'(r0_gnt), 32'd0);
        check_val("hold_addr", 32'(m_slave_addr), 32'd0);
        r0_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("holdoff", 32'(r0_gnt), 32'd0);
        end
        tick();
        check_val("regrant0", 32'(r0_gnt), 32'd1);
        r0_req = 1'b0;
        tick();
        check_val("rel2_gnt0", 32'(r0_gnt), 32'd0);

        // Tie after reset and round-robin
        reset = 1'b1;
        tick();
        reset = 1'b0; r0_req = 1'b1; r1_req = 1'b1;
        tick();
        check_val("tie_gnt0", 32'(r0_gnt), 32'd1);
        check_val("tie_gnt1", 32'(r1_gnt), 32'd0);
        r0_req = 1'b0;
        tick();
        check_val("tie_rel0", 32'(r0_gnt), 32'd0);
        r0_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_val("rr_gnt1", 32'(r1_gnt), 32'd1);
        check_val("rr_gnt0_off", 32'(r0_gnt), 32'd0);
        r1_req = 1'b0;
        tick();
        check_val("rr_rel1", 32'(r1_gnt), 32'd0);
        r1_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_val("rr_gnt0", 32'(r0_gnt), 32'd1);
        check_val("rr_gnt1_off", 32'(r1_gnt), 32'd0);

        // Ungranted go is ignored
        r1_go = 1'b1; m_done = 1'b1;
        settle();
        check_val("ungr_go", 32'(m_go), 32'd0);
        check_val("ungr_done1", 32'(r1_done), 32'd0);
        r1_go = 1'b0; r0_go = 1'b1;
        settle();
        check_val("gr_go", 32'(m_go), 32'd1);
        tick();
        r0_go = 1'b0; m_done = 1'b0;

        // Late release of r1 while master busy
        r0_req = 1'b0;
        tick();
        check_val("late_rel0", 32'(r0_gnt), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_val("late_gnt1", 32'(r1_gnt), 32'd1);
        r1_slave_addr = 7'h22; r1_req = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("late_hold", 32'(r1_gnt), 32'd1);
        end
        check_val("late_addr", 32'(m_slave_addr), 32'h22);
        check_val("late_ready", 32'(r1_ready), 32'd0);
        m_ready = 1'b1;
        tick();
        check_val("late_rel1", 32'(r1_gnt), 32'd0);

        // Watchdog expiry on r0, lockout, r1 served
        r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_val("wd_gnt0", 32'(r0_gnt), 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick();
            check_val("wd_live", 32'(r0_gnt), 32'd1);
        end
        check_val("wd_no_to", 32'(r0_timeout), 32'd0);
        tick();
        check_val("wd_drop", 32'(r0_gnt), 32'd0);
        check_val("wd_pulse", 32'(r0_timeout), 32'd1);
        tick();
        check_val("wd_pulse_end", 32'(r0_timeout), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        tick();
        check_val("wd_gnt1", 32'(r1_gnt), 32'd1);
        r1_req = 1'b0;
        tick();
        check_val("wd_rel1", 32'(r1_gnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("lockout", 32'(r0_gnt), 32'd0);
        end
        r0_req = 1'b0;
        tick();
        r0_req = 1'b1;
        tick();
        check_val("unlock", 32'(r0_gnt), 32'd1);

        // Request dropping during HOLD gets no grant
        r0_req = 1'b0;
        tick();
        check_val("drop_rel0", 32'(r0_gnt), 32'd0);
        r1_req = 1'b1;
        tick(); tick();
        r1_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("drop_nogrant", 32'(r1_gnt), 32'd0);
        end

        // Asynchronous reset during GNT1 with go active
        r1_req = 1'b1;
        tick();
        check_val("ar_gnt1", 32'(r1_gnt), 32'd1);
        r1_go = 1'b1;
        settle();
        check_val("ar_go", 32'(m_go), 32'd1);
        reset = 1'b1;
        settle();
        check_val("ar_gnt_off", 32'(r1_gnt), 32'd0);
        check_val("ar_go_off", 32'(m_go), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_val("ar_restart", 32'(r1_gnt), 32'd1);
        r1_go = 1'b0; r1_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
